// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - request/grant and address-phase control bundle of the 3-master AHB-lite arbiter
interface ahb_arbiter_if;
  logic [2:0] hbusreq;
  logic [2:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [2:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  // Bus-master side: raises requests, drives the muxed transfer control, sees grants.
  modport master (
    output hbusreq,
    output hlock,
    output htrans,
    output hburst,
    output hready,
    input  hgrant,
    input  hmaster,
    input  hmastlock
  );

  // Arbiter side.
  modport slave (
    input  hbusreq,
    input  hlock,
    input  htrans,
    input  hburst,
    input  hready,
    output hgrant,
    output hmaster,
    output hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB-lite arbiter for three masters with burst and lock hold
module ahb_arbiter (
  input logic           hclk,
  input logic           rst,
  ahb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OWN   = 2'd1,
    BURST = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [2:0] grant_q;
  logic [2:0] grant_next;
  logic [1:0] master_q;
  logic       mastlock_q;
  logic [1:0] gidx;
  logic       owner_lock;
  logic       arb_ok;
  logic [2:0] rr_grant;
  logic [1:0] cand0;
  logic [1:0] cand1;

  assign bus.hgrant    = grant_q;
  assign bus.hmaster   = master_q;
  assign bus.hmastlock = mastlock_q;

  // Index of the currently granted master; the grant register is always one-hot.
  always_comb begin
    gidx = 2'd0;
    case (grant_q)
      3'b010:  gidx = 2'd1;
      3'b100:  gidx = 2'd2;
      default: gidx = 2'd0;
    endcase
  end

  assign owner_lock = bus.hlock[gidx];

  // Beat counter update: fixed bursts load beats-1, SEQ counts down, BUSY holds, anything else clears.
  always_comb begin
    cnt_next = cnt;
    case (bus.htrans)
      TRANS_NONSEQ: begin
        case (bus.hburst)
          3'b010, 3'b011: cnt_next = 4'd3;
          3'b100, 3'b101: cnt_next = 4'd7;
          3'b110, 3'b111: cnt_next = 4'd15;
          default:        cnt_next = 4'd0;
        endcase
      end
      TRANS_SEQ:  cnt_next = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
      TRANS_BUSY: cnt_next = cnt;
      TRANS_IDLE: cnt_next = 4'd0;
      default:    cnt_next = 4'd0;
    endcase
  end

  // Re-arbitrate only when the owner is unlocked and at most its final beat remains.
  assign arb_ok = bus.hready && !owner_lock && (cnt_next <= 4'd1);

  // Round-robin pick: start after the current holder, the holder itself is checked last, park on 0.
  always_comb begin
    cand0    = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    cand1    = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    rr_grant = 3'b001;
    if (bus.hbusreq[cand0]) begin
      rr_grant = 3'b001 << cand0;
    end else if (bus.hbusreq[cand1]) begin
      rr_grant = 3'b001 << cand1;
    end else if (bus.hbusreq[gidx]) begin
      rr_grant = 3'b001 << gidx;
    end
  end

  // Next grant and derived state; everything freezes while the bus is stalled.
  always_comb begin
    grant_next = grant_q;
    state_next = state;
    if (bus.hready) begin
      if (arb_ok) begin
        grant_next = rr_grant;
        state_next = (bus.hbusreq == 3'b000) ? PARK : OWN;
      end else if (owner_lock) begin
        state_next = LOCK;
      end else begin
        state_next = BURST;
      end
    end
  end

  // State register.
  always_ff @(posedge hclk) begin
    if (rst) begin
      state <= PARK;
    end else begin
      state <= state_next;
    end
  end

  // Grant, address-mux select, lock flag and beat counter advance only on accepted transfers.
  always_ff @(posedge hclk) begin
    if (rst) begin
      grant_q    <= 3'b001;
      master_q   <= 2'd0;
      mastlock_q <= 1'b0;
      cnt        <= 4'd0;
    end else if (bus.hready) begin
      grant_q    <= grant_next;
      master_q   <= gidx;
      mastlock_q <= owner_lock;
      cnt        <= cnt_next;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for the round-robin AHB-lite arbiter
module tb_ahb_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SGL  = 3'b000;
  localparam logic [2:0] INC  = 3'b001;
  localparam logic [2:0] INC4 = 3'b011;
  localparam logic [2:0] INC8 = 3'b101;

  typedef struct packed {
    logic       r;
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic [2:0] g;
    logic [1:0] m;
    logic       l;
    logic [3:0] c;
  } row_t;

  logic hclk;
  logic rst;
  int   total;
  int   bad;
  row_t sb[$];

  ahb_arbiter_if bus ();

  ahb_arbiter dut (
    .hclk (hclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic row_t mk(logic r, logic [2:0] req, logic [2:0] lock, logic [1:0] tr,
                              logic [2:0] bu, logic rdy, logic [2:0] g, logic [1:0] m,
                              logic l, logic [3:0] c);
    row_t x;
    x = '{r: r, req: req, lock: lock, tr: tr, bu: bu, rdy: rdy, g: g, m: m, l: l, c: c};
    return x;
  endfunction

  task automatic apply(input row_t x);
    rst         = x.r;
    bus.hbusreq = x.req;
    bus.hlock   = x.lock;
    bus.htrans  = x.tr;
    bus.hburst  = x.bu;
    bus.hready  = x.rdy;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 3'b111, 3'b111, SQ, INC8, 0, 3'b001, 0, 0, 0));
    for (int i = 0; i < 5; i++) rows.push_back(mk(0, 0, 0, IDL, SGL, 1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL reset[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 3'b110, 0, IDL, SGL, 1, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, NSQ, SGL, 1, 3'b100, 1, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, NSQ, SGL, 1, 3'b010, 2, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, NSQ, SGL, 1, 3'b100, 1, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, NSQ, SGL, 0, 3'b100, 1, 0, 0));
    rows.push_back(mk(0, 3'b110, 0, NSQ, SGL, 1, 3'b010, 2, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, IDL, SGL, 1, 3'b001, 1, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, IDL, SGL, 1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL round_robin[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  task automatic test_burst_hold();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 3'b010, 0, IDL, SGL,  1, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, IDL, SGL,  1, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b100, 0, NSQ, INC4, 1, 3'b010, 1, 0, 3));
    rows.push_back(mk(0, 3'b100, 0, BSY, INC4, 1, 3'b010, 1, 0, 3));
    rows.push_back(mk(0, 3'b100, 0, SQ,  INC4, 1, 3'b010, 1, 0, 2));
    rows.push_back(mk(0, 3'b100, 0, SQ,  INC4, 0, 3'b010, 1, 0, 2));
    rows.push_back(mk(0, 3'b100, 0, SQ,  INC4, 0, 3'b010, 1, 0, 2));
    rows.push_back(mk(0, 3'b100, 0, SQ,  INC4, 1, 3'b100, 1, 0, 1));
    rows.push_back(mk(0, 3'b100, 0, SQ,  INC4, 1, 3'b100, 2, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, IDL, SGL,  1, 3'b001, 2, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, IDL, SGL,  1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL burst_hold[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 3'b100, 3'b100, IDL, SGL, 1, 3'b100, 0, 0, 0));
    rows.push_back(mk(0, 3'b111, 3'b100, IDL, SGL, 1, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b111, 3'b100, NSQ, SGL, 1, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b111, 3'b100, NSQ, SGL, 1, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b111, 3'b100, NSQ, SGL, 1, 3'b100, 2, 1, 0));
    rows.push_back(mk(0, 3'b011, 3'b000, IDL, SGL, 1, 3'b001, 2, 0, 0));
    rows.push_back(mk(0, 3'b000, 3'b000, IDL, SGL, 1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL lock[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 3'b010, 3'b000, IDL, SGL,  1, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 3'b000, IDL, SGL,  1, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b010, 3'b000, NSQ, INC8, 1, 3'b010, 1, 0, 7));
    rows.push_back(mk(0, 3'b110, 3'b000, SQ,  INC8, 1, 3'b010, 1, 0, 6));
    rows.push_back(mk(0, 3'b110, 3'b000, SQ,  INC8, 1, 3'b010, 1, 0, 5));
    rows.push_back(mk(0, 3'b110, 3'b010, SQ,  INC8, 1, 3'b010, 1, 1, 4));
    rows.push_back(mk(1, 3'b110, 3'b010, SQ,  INC8, 0, 3'b001, 0, 0, 0));
    rows.push_back(mk(0, 3'b000, 3'b000, IDL, SGL,  1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL reset_mid_burst[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  task automatic test_park();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 3'b010, 0, IDL, SGL, 1, 3'b010, 0, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, IDL, SGL, 1, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b010, 0, NSQ, INC, 1, 3'b010, 1, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, SQ,  INC, 1, 3'b001, 1, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, SQ,  INC, 0, 3'b001, 1, 0, 0));
    rows.push_back(mk(0, 3'b000, 0, IDL, SGL, 1, 3'b001, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      sb.push_back(rows[i]);
      @(posedge hclk); #1;
      e = sb.pop_front();
      total++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt} !== {e.g, e.m, e.l, e.c}) begin
        bad++;
        $display("FAIL park[%0d] got g=%b m=%0d l=%b c=%0d want g=%b m=%0d l=%b c=%0d",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock, dut.cnt, e.g, e.m, e.l, e.c);
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.hbusreq = 3'b000;
    bus.hlock   = 3'b000;
    bus.htrans  = IDL;
    bus.hburst  = SGL;
    bus.hready  = 1'b1;
    #1;
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_lock();
    test_reset_mid_burst();
    test_park();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Three-master AHB-lite bus arbiter for the shared 16-bit address/control bus. It grants bus ownership to one master at a time using round-robin priority, and holds the grant through fixed-length bursts and locked sequences. It drives the address-mux select (`hmaster`) and the per-master grants. The slave-select decode is a separate block downstream of the address mux.

## Interface
- No parameters; master count fixed at 3, default (park) master is master 0.
- `hclk`  in  1  bus clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `hbusreq`  in  3  bus request, bit i = master i.
- `hlock`  in  3  locked-access request, bit i = master i.
- `htrans`  in  2  transfer type of current address-phase owner (post-mux): IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hburst`  in  3  burst type of current owner: SINGLE=000, INCR=001, WRAP4/INCR4=010/011, WRAP8/INCR8=100/101, WRAP16/INCR16=110/111.
- `hready`  in  1  transfer done / bus advance.
- `hgrant`  out  3  one-hot grant, registered.
- `hmaster`  out  2  index of address-phase owner (0..2), registered; drives address mux.
- `hmastlock`  out  1  current address-phase transfer is locked, registered.

## Operation
- Reset values: `hgrant`=3'b001, `hmaster`=0, `hmastlock`=0, beat counter `cnt`=0, state PARK.
- Whenever `hready`=0, all registers hold (grant, hmaster, hmastlock, cnt, state).
- Beat counter (4 bits), updated only on edges with `hready`=1:
  - NONSEQ with fixed-length burst loads beats-1: 3, 7 or 15.
  - SEQ with `cnt`>0 decrements.
  - NONSEQ SINGLE/INCR or IDLE clears to 0.
  - BUSY holds.
  - `cnt_next` denotes the post-update value.
- Arbitration allowed (`arb_ok`) on a `hready`=1 edge iff owner's `hlock` bit is low and `cnt_next`≤1. When `cnt_next`=1, the old master drives its final beat while the new grant is already visible.
- Round-robin on `arb_ok`:
  - Search requesters starting at (granted index + 1) mod 3, wrapping.
  - First `hbusreq` bit found wins; current holder is the last candidate.
  - No requests: grant parks on master 0.
- `hmaster` <= index of `hgrant` on every `hready`=1 edge. Handover therefore completes one accepted transfer after the grant change.
- `hmastlock` <= `hlock[granted index]` on every `hready`=1 edge.
- States (derived, for coverage):
  - PARK: no requests, master 0 granted.
  - OWN: a requester is granted and `arb_ok` is possible.
  - BURST: `cnt_next`>1, grant frozen.
  - LOCK: owner `hlock` high, grant frozen.
- Transitions: PARK->OWN on any request. OWN->BURST on fixed-burst NONSEQ. BURST->OWN when `cnt_next`≤1. OWN<->LOCK on owner `hlock`. OWN->PARK when all requests drop at an `arb_ok` edge.
- INCR (undefined length) never blocks re-arbitration; masters must tolerate early grant loss.

## Timing
- Grant latency: request sampled at edge E (`hready`=1, `arb_ok`), `hgrant` valid after E. `hmaster` follows at the next `hready`=1 edge. Minimum request-to-address-ownership is 2 cycles.
- Wait states (`hready`=0) stretch both steps cycle-for-cycle.
- Simultaneous requests: resolved purely by round-robin order; no fixed priority beyond the search start point.
- Lock release: on the edge owner `hlock` drops with `cnt_next`≤1, re-arbitration occurs on that same edge.
- Reset mid-burst or mid-lock: the next edge returns all outputs to reset values irrespective of `hready`, `htrans` or `cnt`.
- `hgrant` always one-hot; `hmaster` never exceeds 2.

## Test plan
- Reset then idle, no requests, `hready`=1 -> `hgrant`=001, `hmaster`=0, `hmastlock`=0, held indefinitely.
- `hbusreq`=110 set together, SINGLE NONSEQ each grant -> grant order 010, 100, 010, ... and `hmaster` lags `hgrant` by exactly one `hready`=1 edge.
- Master 1 INCR4 (NONSEQ + 3 SEQ) with master 2 requesting; insert one BUSY and 2 `hready`=0 cycles -> `hgrant` stays 010 until the edge accepting the 3rd address (`cnt_next`=1). Then 100; `hmaster`=2 after the 4th beat is accepted.
- Master 2 asserts `hlock` over 3 SINGLE transfers while 0 and 1 request -> grant held at 100, `hmastlock`=1 for those transfers; re-arbitration to master 0 on the edge `hlock` drops.
- `rst` pulsed during an INCR8 beat 4 with `hready`=0 -> next edge `hgrant`=001, `hmaster`=0, `cnt`=0, `hmastlock`=0.
- All requests drop while master 1 owns (INCR) -> grant parks 001 on next `hready`=1 edge, `hmaster`=0 one accepted transfer later.
